wb_spi_master: RTL and testbench

Parametrised Wishbone-slave SPI master, the successor to the fixed SPI front end. It runs entirely in the bus clock domain and generates SPI_CLK with an enable counter, so it has no derived clock and no dual-clock buffer. Transfer length, clock divider, SPI mode (CPOL/CPHA), bit order, chip-select count and auto/manual chip-select are all configurable. It sits directly on the system Wishbone bus and drives one SPI bus with NUM_CS slaves.

---
 rtl/wb_spi_master.sv | 206 ++++++++++++++++++++
 tb/tb_wb_spi_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_master.sv
`default_nettype none
// ============================================================================
// Module : wb_spi_master
// Wishbone-slave SPI master with a clock-enable divider and configurable mode,
// length, bit order and chip selects.
// Rev    : 1.0
// ============================================================================
module wb_spi_master #(
    parameter int MAX_LEN   = 32,
    parameter int NUM_CS    = 4,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 3
) (
    input  logic              CLK_I,
    input  logic              RST_N_I,
    input  logic [7:0]        ADR_I,
    input  logic [31:0]       DAT_I,
    output logic [31:0]       DAT_O,
    input  logic              WE_I,
    input  logic              STB_I,
    input  logic              CYC_I,
    output logic              ACK_O,
    output logic              IRQ_O,
    output logic              SPI_CLK,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO,
    output logic [NUM_CS-1:0] SPI_CS_N
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_lead  = 2'd1;
    localparam logic [1:0] c_shift = 2'd2;
    localparam logic [1:0] c_trail = 2'd3;

    localparam logic [2:0] c_a_ctrl   = 3'd0;
    localparam logic [2:0] c_a_div    = 3'd1;
    localparam logic [2:0] c_a_ss     = 3'd2;
    localparam logic [2:0] c_a_tx     = 3'd3;
    localparam logic [2:0] c_a_rx     = 3'd4;
    localparam logic [2:0] c_a_status = 3'd5;

    localparam logic [4:0] c_len_max = 5'(MAX_LEN - 1);

    logic [1:0]        r_state;
    logic [DIV_W-1:0]  r_cnt;
    logic [5:0]        r_edge;
    logic              r_cpol, r_cpha, r_lsb, r_auto_cs, r_ie;
    logic [4:0]        r_len;
    logic [DIV_W-1:0]  r_div;
    logic [NUM_CS-1:0] r_ss;
    logic [31:0]       r_tx;
    logic [31:0]       r_rx_sh;
    logic [31:0]       r_rx;
    logic              r_done;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_sclk;
    logic              r_mosi;

    logic        w_busy, w_acc, w_wr, w_cfg_wr, w_ctrl_wr, w_go, w_done_clr;
    logic [2:0]  w_adr;
    logic [4:0]  w_len_in, w_first_idx, w_bit_n, w_idx_cur, w_idx_nxt;
    logic        w_half_end, w_sample, w_last_bit;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_busy      = (r_state != c_idle);
    assign w_acc       = STB_I & CYC_I & ~r_ack;
    assign w_wr        = w_acc & WE_I;
    assign w_adr       = ADR_I[4:2];
    assign w_cfg_wr    = w_wr & ~w_busy;
    assign w_ctrl_wr   = w_cfg_wr & (w_adr == c_a_ctrl);
    assign w_go        = w_ctrl_wr & DAT_I[0];
    assign w_done_clr  = w_wr & (w_adr == c_a_status) & DAT_I[1];
    assign w_len_in    = (DAT_I[12:8] > c_len_max) ? c_len_max : DAT_I[12:8];
    assign w_first_idx = DAT_I[3] ? 5'd0 : w_len_in;
    assign w_unused    = &{1'b0, ADR_I[7:5], ADR_I[1:0]};

    // Even SHIFT half-periods end on a leading edge, odd ones on a trailing edge.
    assign w_half_end = (r_cnt == '0);
    assign w_bit_n    = r_edge[5:1];
    assign w_sample   = ~r_edge[0] ^ r_cpha;
    assign w_last_bit = (w_bit_n == r_len);
    assign w_idx_cur  = r_lsb ? w_bit_n : (r_len - w_bit_n);
    assign w_idx_nxt  = r_lsb ? (w_bit_n + 5'd1) : (r_len - w_bit_n - 5'd1);

    always_comb begin
        w_rdata = 32'd0;
        case (w_adr)
            c_a_ctrl:   w_rdata = {19'd0, r_len, 2'b00, r_ie, r_auto_cs, r_lsb, r_cpha, r_cpol, 1'b0};
            c_a_div:    w_rdata = 32'(r_div);
            c_a_ss:     w_rdata = 32'(r_ss);
            c_a_tx:     w_rdata = r_tx;
            c_a_rx:     w_rdata = r_rx;
            c_a_status: w_rdata = {30'd0, r_done, w_busy};
            default:    w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_ack     <= 1'b0;
            r_dat     <= 32'd0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            r_auto_cs <= 1'b0;
            r_ie      <= 1'b0;
            r_len     <= 5'd0;
            r_div     <= DIV_W'(DIV_RESET);
            r_ss      <= '0;
            r_tx      <= 32'd0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) r_dat <= w_rdata;
            if (w_cfg_wr) begin
                case (w_adr)
                    c_a_ctrl: begin
                        r_cpol    <= DAT_I[1];
                        r_cpha    <= DAT_I[2];
                        r_lsb     <= DAT_I[3];
                        r_auto_cs <= DAT_I[4];
                        r_ie      <= DAT_I[5];
                        r_len     <= w_len_in;
                    end
                    c_a_div: r_div <= DAT_I[DIV_W-1:0];
                    c_a_ss:  r_ss  <= DAT_I[NUM_CS-1:0];
                    c_a_tx:  r_tx  <= DAT_I;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_edge  <= 6'd0;
            r_rx_sh <= 32'd0;
            r_rx    <= 32'd0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            if (w_done_clr) r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_sclk <= w_ctrl_wr ? DAT_I[1] : r_cpol;
                    if (w_go) begin
                        r_state <= c_lead;
                        r_cnt   <= r_div;
                        r_rx_sh <= 32'd0;
                        if (!DAT_I[2]) r_mosi <= r_tx[w_first_idx];
                    end
                end
                c_lead: begin
                    if (w_half_end) begin
                        r_state <= c_shift;
                        r_cnt   <= r_div;
                        r_edge  <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_shift: begin
                    if (w_half_end) begin
                        r_sclk <= ~r_sclk;
                        r_cnt  <= r_div;
                        if (w_sample)
                            r_rx_sh[w_idx_cur] <= SPI_MISO;
                        else if (r_cpha)
                            r_mosi <= r_tx[w_idx_cur];
                        else if (!w_last_bit)
                            r_mosi <= r_tx[w_idx_nxt];
                        if (r_edge == {r_len, 1'b1})
                            r_state <= c_trail;
                        else
                            r_edge <= r_edge + 6'd1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_trail: begin
                    if (w_half_end) begin
                        r_state <= c_idle;
                        r_done  <= 1'b1;
                        r_rx    <= r_rx_sh;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign ACK_O    = r_ack;
    assign DAT_O    = r_dat;
    assign IRQ_O    = r_done & r_ie;
    assign SPI_CLK  = r_sclk;
    assign SPI_MOSI = r_mosi;
    assign SPI_CS_N = (r_auto_cs & ~w_busy) ? {NUM_CS{1'b1}} : ~r_ss;

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_master.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_spi_master
// Self-checking bench for wb_spi_master with a behavioural SPI slave model.
// Rev    : 1.0
// ============================================================================
module tb_wb_spi_master;

    localparam int MAX_LEN   = 16;
    localparam int NUM_CS    = 4;
    localparam int DIV_W     = 4;
    localparam int DIV_RESET = 3;

    localparam logic [7:0] c_a_ctrl = 8'h00;
    localparam logic [7:0] c_a_div  = 8'h04;
    localparam logic [7:0] c_a_ss   = 8'h08;
    localparam logic [7:0] c_a_tx   = 8'h0C;
    localparam logic [7:0] c_a_rx   = 8'h10;
    localparam logic [7:0] c_a_st   = 8'h14;
    localparam logic [7:0] c_a_none = 8'h18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  adr_i = 8'd0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic        ack_o, irq_o, spi_clk, spi_mosi, spi_miso;
    logic [NUM_CS-1:0] cs_n;

    int checks = 0;
    int failures = 0;

    // Slave model and expectation state
    logic        slave_active = 1'b0;
    logic        loopback = 1'b0;
    logic        s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, s_miso = 1'b0;
    logic [31:0] s_word = 32'd0;
    int          s_len = 0, s_idx = 0;
    logic [31:0] obs_word = 32'd0;
    int          obs_n = 0, pulses = 0;
    int          cs_low_cnt = 0;
    logic [NUM_CS-1:0] cs_seen = '1;
    logic [31:0] e_tx, e_rx;
    int          e_busy, e_len;

    assign spi_miso = loopback ? spi_mosi : s_miso;

    wb_spi_master #(
        .MAX_LEN(MAX_LEN), .NUM_CS(NUM_CS), .DIV_W(DIV_W), .DIV_RESET(DIV_RESET)
    ) dut (
        .CLK_I(clk), .RST_N_I(rst_n), .ADR_I(adr_i), .DAT_I(dat_i), .DAT_O(dat_o),
        .WE_I(we_i), .STB_I(stb_i), .CYC_I(cyc_i), .ACK_O(ack_o), .IRQ_O(irq_o),
        .SPI_CLK(spi_clk), .SPI_MOSI(spi_mosi), .SPI_MISO(spi_miso), .SPI_CS_N(cs_n)
    );

    initial forever #5 clk = ~clk;

    function automatic logic sbit(input logic [31:0] w, input int i, input int len, input logic lsb);
        if (i > len) return 1'b0;
        return lsb ? w[i] : w[len-i];
    endfunction

    // Slave: shifts on the edge the master does not sample on, samples on the other.
    initial forever begin
        @(spi_clk);
        if (slave_active) begin
            if ((spi_clk !== s_cpol) != s_cpha) begin
                if (spi_clk !== s_cpol) pulses++;
                if (obs_n <= s_len) obs_word[s_lsb ? obs_n : s_len - obs_n] = spi_mosi;
                obs_n++;
            end else begin
                if (spi_clk !== s_cpol) pulses++;
                if (!s_cpha) s_idx++;
                s_miso = sbit(s_word, s_idx, s_len, s_lsb);
                if (s_cpha) s_idx++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cs_n !== '1) begin
            cs_low_cnt++;
            cs_seen = cs_n;
        end
    end

    task automatic wb_access(input logic we, input logic [7:0] adr, input logic [31:0] dat);
        int n;
        @(negedge clk);
        adr_i = adr; dat_i = dat; we_i = we; stb_i = 1'b1; cyc_i = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (ack_o !== 1'b1 && n < 8);
        checks++;
        if (ack_o !== 1'b1) begin
            failures++;
            $display("FAIL wb_ack adr=%h got=%b want=1", adr, ack_o);
        end
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
        wb_access(1'b1, adr, dat);
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
        wb_access(1'b0, adr, 32'd0);
        dat = dat_o;
    endtask

    task automatic start_xfer(input logic cpol, input logic cpha, input logic lsb, input logic ie,
                              input int len, input int div, input logic [31:0] tx,
                              input logic [31:0] sw, input logic lp, input logic [3:0] ss);
        logic [31:0] ctrl, mask;
        e_len  = (len > MAX_LEN - 1) ? MAX_LEN - 1 : len;
        mask   = 32'((64'd1 << (e_len + 1)) - 64'd1);
        e_tx   = tx & mask;
        e_rx   = (lp ? tx : sw) & mask;
        e_busy = (div + 1) * (2 * e_len + 4);
        ctrl   = {19'd0, 5'(len), 2'b00, ie, 1'b1, lsb, cpha, cpol, 1'b0};
        wb_write(c_a_div, 32'(div));
        wb_write(c_a_ss, 32'(ss));
        wb_write(c_a_tx, tx);
        wb_write(c_a_ctrl, ctrl);
        s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; s_len = e_len;
        s_word = sw; loopback = lp; s_idx = 0; obs_word = 32'd0; obs_n = 0; pulses = 0;
        s_miso = cpha ? 1'b0 : sbit(sw, 0, e_len, lsb);
        slave_active = 1'b1;
        cs_low_cnt = 0;
        wb_write(c_a_ctrl, ctrl | 32'd1);
    endtask

    task automatic finish_xfer(input string name);
        logic [31:0] d;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (cs_n === '1) break;
        end
        slave_active = 1'b0;
        checks++;
        if (cs_n !== '1) begin
            failures++;
            $display("FAIL %s_timeout cs_n=%h want=all-ones", name, cs_n);
        end
        checks++;
        if (cs_low_cnt != e_busy) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d want=%0d", name, cs_low_cnt, e_busy);
        end
        checks++;
        if (pulses != e_len + 1) begin
            failures++;
            $display("FAIL %s_pulses got=%0d want=%0d", name, pulses, e_len + 1);
        end
        checks++;
        if (obs_word !== e_tx) begin
            failures++;
            $display("FAIL %s_mosi got=%h want=%h", name, obs_word, e_tx);
        end
        wb_read(c_a_rx, d);
        checks++;
        if (d !== e_rx) begin
            failures++;
            $display("FAIL %s_rxdata got=%h want=%h", name, d, e_rx);
        end
        wb_read(c_a_st, d);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("FAIL %s_status got=%h want=%h", name, d, 32'h2);
        end
        checks++;
        if (spi_clk !== s_cpol) begin
            failures++;
            $display("FAIL %s_sclk_idle got=%b want=%b", name, spi_clk, s_cpol);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack_o, irq_o, spi_clk, spi_mosi, cs_n, dat_o} !== {4'b0000, 4'hF, 32'd0}) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b %h %h want=0000 f 0",
                     ack_o, irq_o, spi_clk, spi_mosi, cs_n, dat_o);
        end
        rst_n = 1'b1;
        wb_read(c_a_div, d);
        checks++;
        if (d !== 32'(DIV_RESET)) begin failures++; $display("FAIL reset_div got=%h want=%h", d, DIV_RESET); end
        wb_read(c_a_ctrl, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h want=0", d); end
        wb_read(c_a_st, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%h want=0", d); end
    endtask

    task automatic test_mode0();
        start_xfer(1'b0, 1'b0, 1'b0, 1'b0, 7, 0, 32'hA5, 32'h0, 1'b1, 4'h1);
        finish_xfer("mode0");
        checks++;
        if (cs_seen !== 4'hE) begin failures++; $display("FAIL mode0_cs got=%h want=e", cs_seen); end
    endtask

    task automatic test_mode3();
        start_xfer(1'b1, 1'b1, 1'b1, 1'b0, 11, 2, 32'h5C3, 32'h9A1, 1'b0, 4'h2);
        finish_xfer("mode3");
    endtask

    task automatic test_busy_writes();
        logic [31:0] d;
        start_xfer(1'b0, 1'b1, 1'b0, 1'b0, 7, 3, 32'h3C, 32'h5A, 1'b0, 4'h4);
        wb_write(c_a_tx, 32'hFF);
        wb_write(c_a_div, 32'd9);
        wb_read(c_a_tx, d);
        checks++;
        if (d !== 32'h3C) begin failures++; $display("FAIL busy_tx_kept got=%h want=3c", d); end
        wb_read(c_a_div, d);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL busy_div_kept got=%h want=3", d); end
        finish_xfer("busy_wr");
    endtask

    task automatic test_irq();
        logic [31:0] d;
        start_xfer(1'b1, 1'b0, 1'b1, 1'b1, 5, 1, 32'h2D, 32'h13, 1'b0, 4'h8);
        finish_xfer("irq");
        checks++;
        if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_set got=%b want=1", irq_o); end
        wb_write(c_a_st, 32'h2);
        checks++;
        if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b want=0", irq_o); end
        wb_read(c_a_st, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL done_clear got=%h want=0", d); end
        wb_read(c_a_none, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL unmapped_read got=%h want=0", d); end
    endtask

    task automatic test_cs_manual();
        wb_write(c_a_ss, 32'h5);
        wb_write(c_a_ctrl, 32'h0);
        checks++;
        if (cs_n !== 4'hA) begin failures++; $display("FAIL cs_manual got=%h want=a", cs_n); end
        wb_write(c_a_ctrl, 32'h10);
        checks++;
        if (cs_n !== 4'hF) begin failures++; $display("FAIL cs_auto_idle got=%h want=f", cs_n); end
    endtask

    task automatic test_len_clamp();
        logic [31:0] d;
        wb_write(c_a_ctrl, 32'h1F00);
        wb_read(c_a_ctrl, d);
        checks++;
        if (d[12:8] !== 5'd15) begin failures++; $display("FAIL len_clamp got=%0d want=15", d[12:8]); end
        start_xfer(1'b0, 1'b0, 1'b0, 1'b0, 31, 0, 32'hBEEF_1234, 32'h0000_C0DE, 1'b0, 4'h1);
        finish_xfer("clamp");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            start_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                       $urandom, $urandom, 1'b0, 4'($urandom_range(1, 15)));
            finish_xfer("random");
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        wb_write(c_a_div, 32'd5);
        acks = 0;
        @(negedge clk);
        adr_i = c_a_div; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack_o === 1'b1) begin
                acks++;
                checks++;
                if (dat_o !== 32'd5) begin failures++; $display("FAIL b2b_data got=%h want=5", dat_o); end
            end
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        checks++;
        if (acks != 3) begin failures++; $display("FAIL b2b_acks got=%0d want=3", acks); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        start_xfer(1'b1, 1'b0, 1'b0, 1'b1, 15, 3, 32'hFFFF, 32'h0, 1'b0, 4'hF);
        repeat (12) @(negedge clk);
        slave_active = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_n, spi_clk, spi_mosi, ack_o, irq_o} !== {4'hF, 4'b0000}) begin
            failures++;
            $display("FAIL reset_mid got=%h %b%b%b%b want=f 0000", cs_n, spi_clk, spi_mosi, ack_o, irq_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wb_read(c_a_st, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_mid_status got=%h want=0", d); end
        wb_read(c_a_div, d);
        checks++;
        if (d !== 32'(DIV_RESET)) begin failures++; $display("FAIL reset_mid_div got=%h want=%h", d, DIV_RESET); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_busy_writes();
        test_irq();
        test_cs_manual();
        test_len_clamp();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
